// File: rtl/linescanner_pkg.sv
// Shared definitions for the linescanner pixel path: pixel/stream widths,
// the byte-shifter state encoding and small byte-lane helpers.
package linescanner_pkg;

    localparam int PIXEL_WIDTH    = 8;
    localparam int STREAM_WIDTH   = 32;
    localparam int BYTES_PER_WORD = 4;
    localparam int INDEX_WIDTH    = $clog2(BYTES_PER_WORD);

    typedef enum logic {
        EMPTY = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Extract byte lane idx from a stream word (lane 0 = bits [7:0]).
    function automatic logic [PIXEL_WIDTH-1:0] word_byte(
        input logic [STREAM_WIDTH-1:0] word,
        input logic [INDEX_WIDTH-1:0]  idx
    );
        return word[idx*PIXEL_WIDTH +: PIXEL_WIDTH];
    endfunction

    // One-hot mask selecting byte lane idx.
    function automatic logic [BYTES_PER_WORD-1:0] byte_bit(
        input logic [INDEX_WIDTH-1:0] idx
    );
        logic [BYTES_PER_WORD-1:0] m;
        m      = '0;
        m[idx] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/keep_byte_selector.sv
// Combinational helper for a byte-pending mask: finds the lowest pending
// lane, and flags whether exactly one lane is pending and whether that lowest
// lane is also the highest pending lane (i.e. it is the last byte of the word).
module keep_byte_selector
    import linescanner_pkg::*;
(
    input  logic [BYTES_PER_WORD-1:0] mask,
    output logic [INDEX_WIDTH-1:0]    lowest_idx,
    output logic                      one_left,
    output logic                      is_highest
);

    // Priority search, scanning downward so the lowest set lane wins.
    always_comb begin
        lowest_idx = '0;
        for (int k = BYTES_PER_WORD - 1; k >= 0; k--) begin
            if (mask[k]) begin
                lowest_idx = INDEX_WIDTH'(k);
            end
        end
    end

    // Remaining-count and last-lane flags; both are 0 for an empty mask.
    always_comb begin
        one_left   = ($countones(mask) == 1);
        is_highest = ((mask >> lowest_idx) == BYTES_PER_WORD'(1));
    end

endmodule

// File: rtl/stream2linescanner_convertor.sv
// 32-bit AXI4-Stream to 8-bit linescanner pixel converter.
// Each accepted word is buffered and emitted one byte per pixel handshake,
// lowest lane first, skipping lanes whose keep bit is clear. tlast becomes
// line_end on the final emitted byte of the word.
//
// Optional build macro: STREAM2LS_LINE_CHECK_EN adds the LINE_PIXELS
// parameter, a per-line pixel counter and the line_error pulse output.
//
// state | meaning
// ------+------------------------------------------------------------
// EMPTY | no pending bytes; ready for a word when enabled
// SHIFT | pending mask non-zero; presenting buffer byte[byte_idx]
module stream2linescanner_convertor
    import linescanner_pkg::*;
`ifdef STREAM2LS_LINE_CHECK_EN
#(
    parameter int LINE_PIXELS = 2048
)
`endif
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [STREAM_WIDTH-1:0]   stream_data,
    input  logic                      stream_data_valid,
    output logic                      stream_ready,
    input  logic [BYTES_PER_WORD-1:0] keep_data,
    input  logic                      last_data,
    output logic [PIXEL_WIDTH-1:0]    output_data,
    output logic                      data_ready,
    input  logic                      pixel_captured,
    output logic                      line_end
`ifdef STREAM2LS_LINE_CHECK_EN
    ,
    output logic                      line_error
`endif
);

    state_t                    state;
    logic [STREAM_WIDTH-1:0]   word_buf;
    logic [BYTES_PER_WORD-1:0] pending;
    logic                      last_flag;
    logic [INDEX_WIDTH-1:0]    byte_idx;
    logic                      one_left_q;

    logic                      pixel_hs;
    logic                      word_accept;
    logic [BYTES_PER_WORD-1:0] next_mask;
    logic [STREAM_WIDTH-1:0]   next_buf;
    logic                      next_last;
    logic [INDEX_WIDTH-1:0]    sel_idx;
    logic                      sel_one;
    logic                      sel_highest;

    // Pixel handshake only counts while a pixel is actually presented.
    assign pixel_hs = data_ready && pixel_captured;

    // Ready when idle, or when the only pending byte leaves this cycle, so
    // consecutive words stream without a bubble.
    assign stream_ready = enable && !reset &&
                          ((state == EMPTY) || (pixel_hs && one_left_q));

    assign word_accept = stream_data_valid && stream_ready;

    // Next buffer contents: a new word overrides the drain of the old one.
    always_comb begin
        next_mask = pending;
        next_buf  = word_buf;
        next_last = last_flag;
        if (pixel_hs) begin
            next_mask = pending & ~byte_bit(byte_idx);
        end
        if (word_accept) begin
            next_mask = keep_data;
            next_buf  = stream_data;
            next_last = last_data;
        end
    end

    // The selector looks at the next mask so the outputs can be registered.
    keep_byte_selector u_keep_byte_selector (
        .mask       (next_mask),
        .lowest_idx (sel_idx),
        .one_left   (sel_one),
        .is_highest (sel_highest)
    );

    // Byte-shifter FSM with registered pixel outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= EMPTY;
            word_buf    <= '0;
            pending     <= '0;
            last_flag   <= 1'b0;
            byte_idx    <= '0;
            one_left_q  <= 1'b0;
            data_ready  <= 1'b0;
            output_data <= '0;
            line_end    <= 1'b0;
        end else begin
            word_buf   <= next_buf;
            pending    <= next_mask;
            last_flag  <= next_last;
            byte_idx   <= sel_idx;
            one_left_q <= sel_one;
            if (next_mask != '0) begin
                state       <= SHIFT;
                data_ready  <= 1'b1;
                output_data <= word_byte(next_buf, sel_idx);
                line_end    <= next_last && sel_highest;
            end else begin
                // Also covers a keep=0 word: it is swallowed with no pixel.
                state       <= EMPTY;
                data_ready  <= 1'b0;
                output_data <= '0;
                line_end    <= 1'b0;
            end
        end
    end

`ifdef STREAM2LS_LINE_CHECK_EN
    localparam int               CNT_W    = $clog2(LINE_PIXELS + 1);
    localparam logic [CNT_W-1:0] LINE_LEN = CNT_W'(LINE_PIXELS);

    logic [CNT_W-1:0] pix_cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             empty_last;

    assign cnt_inc    = pix_cnt + CNT_W'(1);
    // A keep=0 word carrying tlast ends the line with no line_end pixel.
    assign empty_last = word_accept && (keep_data == '0) && last_data;

    // Line-length checker: pulse on a short line end or an overlong line.
    always_ff @(posedge clk) begin
        if (reset) begin
            pix_cnt    <= '0;
            line_error <= 1'b0;
        end else begin
            line_error <= 1'b0;
            if (empty_last) begin
                line_error <= 1'b1;
                pix_cnt    <= '0;
            end else if (pixel_hs) begin
                if (line_end || (cnt_inc == LINE_LEN)) begin
                    line_error <= (cnt_inc != LINE_LEN) || !line_end;
                    pix_cnt    <= '0;
                end else begin
                    pix_cnt <= cnt_inc;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_stream2linescanner_convertor.sv
// Scoreboard bench for stream2linescanner_convertor. Expected pixels are
// queued as each stream word is accepted and popped on every pixel handshake.
// Line-length checks are exercised when STREAM2LS_LINE_CHECK_EN is defined.
module tb_stream2linescanner_convertor;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [31:0] stream_data;
    logic        stream_data_valid;
    logic        stream_ready;
    logic [3:0]  keep_data;
    logic        last_data;
    logic [7:0]  output_data;
    logic        data_ready;
    logic        pixel_captured;
    logic        line_end;

    always #5 clk = ~clk;

`ifdef STREAM2LS_LINE_CHECK_EN
    logic line_error;
    stream2linescanner_convertor #(.LINE_PIXELS(8)) dut (
        .clk               (clk),
        .reset             (reset),
        .enable            (enable),
        .stream_data       (stream_data),
        .stream_data_valid (stream_data_valid),
        .stream_ready      (stream_ready),
        .keep_data         (keep_data),
        .last_data         (last_data),
        .output_data       (output_data),
        .data_ready        (data_ready),
        .pixel_captured    (pixel_captured),
        .line_end          (line_end),
        .line_error        (line_error)
    );
`else
    stream2linescanner_convertor dut (
        .clk               (clk),
        .reset             (reset),
        .enable            (enable),
        .stream_data       (stream_data),
        .stream_data_valid (stream_data_valid),
        .stream_ready      (stream_ready),
        .keep_data         (keep_data),
        .last_data         (last_data),
        .output_data       (output_data),
        .data_ready        (data_ready),
        .pixel_captured    (pixel_captured),
        .line_end          (line_end)
    );
`endif

    int         n_vec = 0;
    int         n_err = 0;
    logic [8:0] sb[$];
    int         pc_mode = 1;
    int         run_len = 0;
    int         max_run = 0;
    int         px_total = 0;
    int         err_cnt = 0;
    int         first_err_at = 0;
    logic       prev_stall = 1'b0;
    logic [8:0] prev_out = '0;
    int         wt;
    int         p0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Consumer: pixel_captured pattern, changed just after each rising edge.
    initial begin
        pixel_captured = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (pc_mode)
                0:       pixel_captured = 1'b0;
                1:       pixel_captured = 1'b1;
                default: pixel_captured = ~pixel_captured;
            endcase
        end
    end

    // Monitor: sampled on the falling edge, away from the active edge.
    initial begin
        logic [8:0] exp_px;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall = 1'b0;
                run_len    = 0;
            end else begin
`ifdef STREAM2LS_LINE_CHECK_EN
                if (line_error) begin
                    err_cnt++;
                    if (err_cnt == 1) first_err_at = px_total;
                end
`endif
                if (!data_ready) check_eq("le_idle", 32'(line_end), 32'd0);
                if (prev_stall)
                    check_eq("hold", 32'({data_ready, line_end, output_data}), 32'({1'b1, prev_out}));
                if (data_ready && pixel_captured) begin
                    check_eq("sb_pending", 32'(sb.size() > 0), 32'd1);
                    if (sb.size() > 0) begin
                        exp_px = sb.pop_front();
                        check_eq("pixel", 32'({line_end, output_data}), 32'(exp_px));
                    end
                    px_total++;
                    run_len++;
                    if (run_len > max_run) max_run = run_len;
                end else begin
                    run_len = 0;
                end
                prev_stall = data_ready && !pixel_captured;
                prev_out   = {line_end, output_data};
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Expected pixels of one word: kept lanes in ascending order, line_end
    // on the highest kept lane when tlast is set.
    task automatic push_word(input logic [31:0] d, input logic [3:0] k, input logic l);
        int hi;
        hi = -1;
        for (int i = 0; i < 4; i++) if (k[i]) hi = i;
        for (int i = 0; i < 4; i++)
            if (k[i]) sb.push_back({l && (i == hi), d[8*i +: 8]});
    endtask

    // Offer one word (called at posedge+2); returns the cycles spent waiting.
    task automatic send_word(input logic [31:0] d, input logic [3:0] k, input logic l, output int waited);
        stream_data       = d;
        keep_data         = k;
        last_data         = l;
        stream_data_valid = 1'b1;
        #1;
        waited = 0;
        while (!stream_ready && waited < 200) begin
            @(posedge clk);
            #3;
            waited++;
        end
        check_eq("accepted", 32'(stream_ready), 32'd1);
        push_word(d, k, l);
        @(posedge clk);
        #2;
        stream_data_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || data_ready) && n < 500) begin
            step(1);
            n++;
        end
        check_eq("drain", 32'(sb.size()), 32'd0);
        step(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset             = 1'b1;
        enable            = 1'b1;
        stream_data       = '0;
        stream_data_valid = 1'b0;
        keep_data         = '0;
        last_data         = 1'b0;
        step(2);
        check_eq("rst_ready",  32'(stream_ready), 32'd0);
        check_eq("rst_dready", 32'(data_ready),   32'd0);
        check_eq("rst_data",   32'(output_data),  32'd0);
        check_eq("rst_lend",   32'(line_end),     32'd0);
`ifdef STREAM2LS_LINE_CHECK_EN
        check_eq("rst_lerr",   32'(line_error),   32'd0);
`endif
        reset = 1'b0;
        step(1);
        check_eq("idle_ready", 32'(stream_ready), 32'd1);

        // Two full words back to back, 1 pixel/cycle.
        pc_mode = 1;
        max_run = 0;
        send_word(32'h44332211, 4'hF, 1'b0, wt);
        check_eq("latency", 32'(data_ready), 32'd1);
        check_eq("first_px", 32'(output_data), 32'h11);
        send_word(32'h88776655, 4'hF, 1'b1, wt);
        check_eq("b2b_wait", 32'(wt), 32'd3);
        wait_drain();
        check_eq("b2b_run", 32'(max_run), 32'd8);

        // Sparse keep: lanes 1 and 3 only.
        send_word(32'hDDCCBBAA, 4'b1010, 1'b1, wt);
        wait_drain();

        // Alternating capture: every pixel held for two cycles.
        pc_mode = 2;
        p0 = px_total;
        send_word(32'h0403_0201, 4'hF, 1'b0, wt);
        send_word(32'h0807_0605, 4'hF, 1'b1, wt);
        wait_drain();
        check_eq("toggle_cnt", 32'(px_total - p0), 32'd8);
        pc_mode = 1;
        step(1);

        // keep=0 word sandwiched between full words.
        p0 = px_total;
        send_word(32'hA3A2A1A0, 4'hF, 1'b0, wt);
        send_word(32'hDEADBEEF, 4'h0, 1'b0, wt);
        send_word(32'hB3B2B1B0, 4'hF, 1'b1, wt);
        check_eq("k0_next_wait", 32'(wt), 32'd0);
        wait_drain();
        check_eq("k0_pixels", 32'(px_total - p0), 32'd8);

        // enable dropped after the first word: it drains, the next word waits.
        send_word(32'hC3C2C1C0, 4'hF, 1'b0, wt);
        enable = 1'b0;
        fork
            send_word(32'hE3E2E1E0, 4'hF, 1'b1, wt);
            begin
                repeat (6) begin
                    @(negedge clk);
                    #1;
                    check_eq("en_ready", 32'(stream_ready), 32'd0);
                end
                check_eq("en_drained", 32'(sb.size()), 32'd0);
                check_eq("en_idle", 32'(data_ready), 32'd0);
                @(posedge clk);
                #2;
                enable = 1'b1;
            end
        join
        wait_drain();

        // Reset while a pixel is stalled mid-word.
        pc_mode = 0;
        step(1);
        send_word(32'h9F9E9D9C, 4'hF, 1'b1, wt);
        step(1);
        check_eq("stall_dready", 32'(data_ready), 32'd1);
        check_eq("stall_data", 32'(output_data), 32'h9C);
        reset = 1'b1;
        step(1);
        check_eq("midrst_dready", 32'(data_ready), 32'd0);
        check_eq("midrst_data", 32'(output_data), 32'd0);
        sb.delete();
        reset   = 1'b0;
        pc_mode = 1;
        step(2);
        check_eq("post_rst_ready", 32'(stream_ready), 32'd1);

`ifdef STREAM2LS_LINE_CHECK_EN
        // LINE_PIXELS = 8: overlong (12), short (4) and exact (8) lines.
        err_cnt = 0;
        p0 = px_total;
        send_word(32'h13121110, 4'hF, 1'b0, wt);
        send_word(32'h17161514, 4'hF, 1'b0, wt);
        send_word(32'h1B1A1918, 4'hF, 1'b1, wt);
        wait_drain();
        check_eq("lc12_first_at", 32'(first_err_at - p0), 32'd8);
        check_eq("lc12_errs", 32'(err_cnt), 32'd2);

        err_cnt = 0;
        p0 = px_total;
        send_word(32'h23222120, 4'hF, 1'b1, wt);
        wait_drain();
        check_eq("lc4_errs", 32'(err_cnt), 32'd1);
        check_eq("lc4_at", 32'(first_err_at - p0), 32'd4);

        err_cnt = 0;
        send_word(32'h33323130, 4'hF, 1'b0, wt);
        send_word(32'h37363534, 4'hF, 1'b1, wt);
        wait_drain();
        check_eq("lc8_errs", 32'(err_cnt), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/stream2linescanner_convertor.md
# stream2linescanner_convertor

Converts a 32-bit AXI4-Stream of packed pixels back into the 8-bit, one-pixel-per-handshake linescanner pixel interface. It is the transmit-side counterpart of the linescanner capture path. It feeds a linescanner emulator or display/DAC front end from DMA/VDMA memory reads. Each accepted stream word is buffered and emitted byte by byte, least significant byte first. Bytes with a cleared keep bit are skipped, and the stream's last flag becomes an end-of-line marker.

## Interface
- LINE_PIXELS, 2048: expected pixels per line; used only when line checking is compiled in.
- clk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high; clears all state on the next clk edge.
- enable  in  1  when low, no new words are accepted; buffered bytes still drain.
- stream_data  in  32  pixel word; byte k is bits [8k+7:8k].
- stream_data_valid  in  1  AXI-S tvalid.
- stream_ready  out  1  AXI-S tready.
- keep_data  in  4  AXI-S tkeep; bit k qualifies byte k.
- last_data  in  1  AXI-S tlast; marks the word that ends a line.
- output_data  out  8  current pixel.
- data_ready  out  1  output_data is valid; held until pixel_captured.
- pixel_captured  in  1  the consumer takes the pixel on a cycle where data_ready && pixel_captured.
- line_end  out  1  high together with data_ready on the final pixel of a line.
- line_error  out  1  one-cycle pulse on a line-length mismatch; present only with LINE_CHECK_EN.

## Operation
- Registers:
  - 32-bit word buffer.
  - 4-bit pending mask, initialised from keep_data.
  - 1-bit last flag.
  - 2-bit byte index.
- States:
  - EMPTY: pending mask is 0.
  - SHIFT: pending mask is not 0.
- Word accept on stream_data_valid && stream_ready:
  - Load the buffer and last flag.
  - Load the pending mask with keep_data.
  - Set the byte index to the lowest set keep bit.
- stream_ready is combinational:
  - Asserted when enable is high and either the state is EMPTY, or SHIFT with a pixel handshake on the only remaining pending byte.
  - This allows back-to-back words with no bubble.
- In SHIFT, output_data = buffer byte[index] and data_ready = 1.
- On a pixel handshake:
  - Clear the pending bit for the current byte.
  - Advance the index to the next higher set bit.
  - If no bits remain, go to EMPTY unless a new word is accepted in the same cycle.
- line_end = last flag && current byte is the highest set pending bit.
- A word with keep_data = 0 is accepted and discarded, and no pixel is emitted. If its last_data is set, the line ends without a line_end pulse; under LINE_CHECK_EN this counts as a mismatch.
- Non-contiguous keep is legal. Example: keep 4'b1010 emits byte 1, then byte 3.
- enable low mid-word: the current buffer drains fully; the next word waits.
- Reset mid-line: the buffer is discarded and the line state is cleared. The consumer sees data_ready drop on the next edge.

## Timing
- Reset values:
  - stream_ready = 0 while reset is high; afterwards it follows the rule above.
  - data_ready = 0, output_data = 8'h00, line_end = 0, line_error = 0.
- Latency: a word accepted at edge N presents its first pixel from edge N (registered), i.e. visible in cycle N+1.
- Throughput: 1 pixel/cycle with pixel_captured held high. A full-keep word takes 4 cycles, and stream_ready pulses once per 4 cycles.
- output_data, data_ready and line_end are stable while data_ready && !pixel_captured.
- pixel_captured while data_ready = 0 is ignored.

## Configuration
- STREAM2LS_LINE_CHECK_EN defined:
  - Adds a pixel counter of width $clog2(LINE_PIXELS+1), counting emitted pixels.
  - When the line_end pixel is handshaked with count+1 != LINE_PIXELS, line_error pulses and the counter clears.
  - When the LINE_PIXELS-th pixel is handshaked without line_end, line_error pulses and the counter clears.
  - A correct line clears the counter with no pulse.
  - Reset clears the counter.
- Not defined:
  - The line_error port, counter and LINE_PIXELS use are removed.
  - Data behaviour is identical.

## Structure
- Shared package linescanner_pkg:
  - PIXEL_WIDTH = 8, STREAM_WIDTH = 32, BYTES_PER_WORD = 4.
  - State encoding {EMPTY, SHIFT}.
- Sub-module: keep_byte_selector (combinational). Given a 4-bit mask, it returns the lowest set index, a remaining-count-is-one flag, and an is-highest flag. It is instantiated once in the convertor.

## Test plan
- Reset, then words 32'h44332211 and 32'h88776655 with keep 4'hF, last on the second, pixel_captured always 1 -> output_data sequence 11,22,33,44,55,66,77,88 on consecutive cycles; line_end only with 88; stream_ready never low between the words.
- Word 32'hDDCCBBAA with keep 4'b1010, last = 1 -> pixels BB then DD; line_end with DD.
- pixel_captured toggles 1/0 each cycle -> each pixel is held 2 cycles; no byte lost or duplicated.
- keep 4'h0 word between two full words -> 8 pixels out, zero from the empty word; it is accepted in 1 cycle.
- enable dropped after the first word is accepted -> all 4 bytes emitted, second word stalled with stream_ready = 0 until enable returns.
- LINE_CHECK_EN, LINE_PIXELS = 8:
  - A 12-byte line -> line_error pulses at the 8th pixel.
  - A 4-byte line -> line_error pulses with line_end.
  - An 8-byte line -> no pulse.
